// File: rtl/factor_candidate_dispatcher_if.sv
// Tester-side bus of the trial-factoring dispatcher.
// Master issues start/p/d; slave answers finished/divides.
interface factor_candidate_dispatcher_if #(
  parameter int BITWIDTH = 32
) ();
  logic                test_start;
  logic [BITWIDTH-1:0] test_p;
  logic [BITWIDTH-1:0] test_d;
  logic                test_finished;
  logic                test_divides;

  modport master (
    output test_start, test_p, test_d,
    input  test_finished, test_divides
  );

  modport slave (
    input  test_start, test_p, test_d,
    output test_finished, test_divides
  );
endinterface

// File: rtl/factor_candidate_dispatcher.sv
// Generates d = 2kp+1 candidates, sieves them and drives one tester.
// Optional mod-3 sieve: define SIEVE_MOD3_EN.
module factor_candidate_dispatcher #(
  parameter int BITWIDTH = 32,
  parameter int KWIDTH   = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [BITWIDTH-1:0] cmd_p,
  input  logic [KWIDTH-1:0]   cmd_k_max,
  factor_candidate_dispatcher_if.master tst,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                result_found,
  output logic                result_overflow,
  output logic [BITWIDTH-1:0] result_d,
  output logic [KWIDTH-1:0]   result_k,
  output logic [KWIDTH-1:0]   tested_count,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_ISSUE,
    S_WAIT_ACK, S_WAIT_DONE, S_REPORT
  } state_t;

  state_t state, nxt;

  logic [BITWIDTH-1:0] p_q, d_q, step_q, res_d_q;
  logic [KWIDTH-1:0]   k_q, kmax_q, res_k_q, tested_q;
  logic                found_q, ovf_q;
  logic [1:0]          ack_cnt;

  logic              accept, degen, wide;
  logic [BITWIDTH:0] sum;
  logic              carry, last_k, stop;
  logic              sieve_hit, done_cyc, advance;

  assign accept = cmd_valid && cmd_ready;
  assign degen  = (cmd_p < BITWIDTH'(2)) || (cmd_k_max == '0);
  assign wide   = cmd_p[BITWIDTH-1];
  // Carry out of the widened add flags d leaving the data path.
  assign sum    = {1'b0, d_q} + {1'b0, step_q};
  assign carry  = sum[BITWIDTH];
  assign last_k = (k_q == kmax_q);
  assign stop   = last_k || carry;

`ifdef SIEVE_MOD3_EN
  logic [1:0] r3_q, s3_q, pm3;

  function automatic logic [1:0] mod3(input logic [BITWIDTH-1:0] v);
    logic [1:0] r;
    logic [2:0] t;
    r = 2'd0;
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      t = {r, 1'b0} + {2'b00, v[i]};
      r = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    end
    return r;
  endfunction

  function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign pm3 = mod3(cmd_p);
  assign sieve_hit = ((d_q[2:0] == 3'b001) || (d_q[2:0] == 3'b111))
                   && (r3_q != 2'd0);
`else
  assign sieve_hit = (d_q[2:0] == 3'b001) || (d_q[2:0] == 3'b111);
`endif

  assign done_cyc = (state == S_WAIT_DONE) && tst.test_finished;
  assign advance  = ((state == S_STEP) && !sieve_hit)
                 || (done_cyc && !tst.test_divides);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (accept) nxt = (degen || wide) ? S_REPORT : S_STEP;
      S_STEP:
        if (sieve_hit) nxt = S_ISSUE;
        else if (stop) nxt = S_REPORT;
      S_ISSUE:
        nxt = S_WAIT_ACK;
      S_WAIT_ACK:
        if (!tst.test_finished)   nxt = S_WAIT_DONE;
        else if (ack_cnt == 2'd3) nxt = S_ISSUE;
      S_WAIT_DONE:
        if (tst.test_finished)
          nxt = (tst.test_divides || stop) ? S_REPORT : S_STEP;
      S_REPORT:
        if (result_ready) nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    tst.test_start = 1'b0;
    result_valid   = 1'b0;
    unique case (state)
      S_IDLE:   begin cmd_ready = 1'b1; busy = 1'b0; end
      S_ISSUE:  tst.test_start = 1'b1;
      S_REPORT: result_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p_q      <= '0;
      d_q      <= '0;
      step_q   <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      res_d_q  <= '0;
      res_k_q  <= '0;
      tested_q <= '0;
      found_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ack_cnt  <= '0;
    end else begin
      if (accept) begin
        p_q      <= cmd_p;
        kmax_q   <= cmd_k_max;
        k_q      <= KWIDTH'(1);
        d_q      <= {cmd_p[BITWIDTH-2:0], 1'b1};
        step_q   <= {cmd_p[BITWIDTH-2:0], 1'b0};
        tested_q <= '0;
        found_q  <= 1'b0;
        ovf_q    <= wide && !degen;
        res_d_q  <= '0;
        res_k_q  <= '0;
      end
      if (state == S_ISSUE)         ack_cnt <= '0;
      else if (state == S_WAIT_ACK) ack_cnt <= ack_cnt + 2'd1;
      if (done_cyc) begin
        tested_q <= tested_q + KWIDTH'(1);
        if (tst.test_divides) begin
          found_q <= 1'b1;
          res_d_q <= d_q;
          res_k_q <= k_q;
        end
      end
      if (advance) begin
        if (last_k) begin
          res_k_q <= k_q;
        end else if (carry) begin
          ovf_q   <= 1'b1;
          res_k_q <= k_q;
        end else begin
          k_q <= k_q + KWIDTH'(1);
          d_q <= sum[BITWIDTH-1:0];
        end
      end
    end
  end

`ifdef SIEVE_MOD3_EN
  // r3 tracks d mod 3; s3 is the per-step increment 2p mod 3.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r3_q <= '0;
      s3_q <= '0;
    end else if (accept) begin
      r3_q <= add3(add3(pm3, pm3), 2'd1);
      s3_q <= add3(pm3, pm3);
    end else if (advance && !stop) begin
      r3_q <= add3(r3_q, s3_q);
    end
  end
`endif

  assign tst.test_p      = p_q;
  assign tst.test_d      = d_q;
  assign result_found    = found_q;
  assign result_overflow = ovf_q;
  assign result_d        = res_d_q;
  assign result_k        = res_k_q;
  assign tested_count    = tested_q;

endmodule

// File: tb/tb_factor_candidate_dispatcher.sv
// Randomized bench: two dispatchers (32-bit and 8-bit data path)
// against an arithmetic reference of the candidate search.
module tb_factor_candidate_dispatcher;

  localparam int BW = 32;
  localparam int KW = 16;
`ifdef SIEVE_MOD3_EN
  localparam bit MOD3 = 1'b1;
`else
  localparam bit MOD3 = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic          cmd_valid, cmd_ready, result_valid, result_ready;
  logic [BW-1:0] cmd_p, result_d;
  logic [KW-1:0] cmd_k_max, result_k, tested_count;
  logic          result_found, result_overflow, busy;

  logic          b_cmd_valid, b_cmd_ready, b_result_valid, b_result_ready;
  logic [7:0]    b_cmd_p, b_result_d;
  logic [KW-1:0] b_cmd_k_max, b_result_k, b_tested_count;
  logic          b_result_found, b_result_overflow, b_busy;

  factor_candidate_dispatcher_if #(.BITWIDTH(BW)) tif ();
  factor_candidate_dispatcher_if #(.BITWIDTH(8))  bif ();

  factor_candidate_dispatcher #(.BITWIDTH(BW), .KWIDTH(KW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_p(cmd_p), .cmd_k_max(cmd_k_max),
    .tst(tif.master),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_found(result_found), .result_overflow(result_overflow),
    .result_d(result_d), .result_k(result_k),
    .tested_count(tested_count), .busy(busy)
  );

  factor_candidate_dispatcher #(.BITWIDTH(8), .KWIDTH(KW)) dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_p(b_cmd_p), .cmd_k_max(b_cmd_k_max),
    .tst(bif.master),
    .result_valid(b_result_valid), .result_ready(b_result_ready),
    .result_found(b_result_found), .result_overflow(b_result_overflow),
    .result_d(b_result_d), .result_k(b_result_k),
    .tested_count(b_tested_count), .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned pow2mod(input longint unsigned e0,
                                              input longint unsigned m);
    longint unsigned r, b, e;
    r = 1 % m;
    b = 2 % m;
    e = e0;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Direct enumeration of k = 1..k_max with d = 2kp+1.
  function automatic void model(
    input longint unsigned p, input longint unsigned km, input int bw,
    output bit f, output bit o, output longint unsigned d,
    output longint unsigned k, output longint unsigned cnt);
    longint unsigned lim, dd;
    f = 0; o = 0; d = 0; k = 0; cnt = 0;
    if (p < 2 || km == 0) return;
    lim = 64'd1 << bw;
    for (longint unsigned kk = 1; kk <= km; kk++) begin
      dd = 2 * kk * p + 1;
      if (dd >= lim) begin
        o = 1; k = kk - 1;
        return;
      end
      if ((dd % 8 == 1 || dd % 8 == 7) && !(MOD3 && dd % 3 == 0)) begin
        cnt++;
        if (pow2mod(p, dd) == 1) begin
          f = 1; d = dd; k = kk;
          return;
        end
      end
    end
    k = km;
  endfunction

  // Tester models: answer 2^p mod d == 1 after a random latency.
  bit t_ignore_en = 1'b0;
  int t_lat_min = 1;
  int t_lat_max = 4;
  int t_cnt, b_cnt;
  bit t_busy, t_verdict, b_tbusy, b_verdict;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tif.test_finished <= 1'b1;
      tif.test_divides  <= 1'b0;
      t_busy <= 1'b0;
      t_cnt  <= 0;
    end else if (t_busy) begin
      if (t_cnt <= 1) begin
        tif.test_finished <= 1'b1;
        tif.test_divides  <= t_verdict;
        t_busy <= 1'b0;
      end else t_cnt <= t_cnt - 1;
    end else if (tif.test_start) begin
      if (!(t_ignore_en && $urandom_range(0, 3) == 0)) begin
        t_busy <= 1'b1;
        tif.test_finished <= 1'b0;
        tif.test_divides  <= 1'b0;
        t_cnt <= $urandom_range(t_lat_min, t_lat_max);
        t_verdict <= (pow2mod(64'(tif.test_p), 64'(tif.test_d)) == 1);
      end
    end
  end

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bif.test_finished <= 1'b1;
      bif.test_divides  <= 1'b0;
      b_tbusy <= 1'b0;
      b_cnt   <= 0;
    end else if (b_tbusy) begin
      if (b_cnt <= 1) begin
        bif.test_finished <= 1'b1;
        bif.test_divides  <= b_verdict;
        b_tbusy <= 1'b0;
      end else b_cnt <= b_cnt - 1;
    end else if (bif.test_start) begin
      b_tbusy <= 1'b1;
      bif.test_finished <= 1'b0;
      bif.test_divides  <= 1'b0;
      b_cnt <= 2;
      b_verdict <= (pow2mod(64'(bif.test_p), 64'(bif.test_d)) == 1);
    end
  end

  task automatic run_cmd(input logic [BW-1:0] p, input logic [KW-1:0] km,
                         input int hold);
    bit ef, eo;
    longint unsigned ed, ek, ec;
    int cyc;
    model(64'(p), 64'(km), BW, ef, eo, ed, ek, ec);
    @(negedge sys_clk);
    cmd_p = p; cmd_k_max = km; cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    cyc = 0;
    while (!result_valid && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
    end
    if (!result_valid) begin
      chk("result_timeout", 64'(result_valid), 64'd1);
      return;
    end
    chk("found", 64'(result_found), 64'(ef));
    chk("overflow", 64'(result_overflow), 64'(eo));
    chk("res_d", 64'(result_d), ed);
    chk("res_k", 64'(result_k), ek);
    chk("tested", 64'(tested_count), ec);
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_fields", {result_d, result_k, 7'd0, result_found,
           7'd0, result_overflow}, {ed[BW-1:0], ek[KW-1:0], 7'd0, ef,
           7'd0, eo});
    end
    result_ready = 1'b1;
    @(negedge sys_clk);
    result_ready = 1'b0;
    chk("valid_dropped", 64'(result_valid), 64'd0);
    chk("back_idle", 64'(cmd_ready), 64'd1);
  endtask

  task automatic run8(input logic [7:0] p, input logic [KW-1:0] km);
    bit ef, eo;
    longint unsigned ed, ek, ec;
    int cyc;
    model(64'(p), 64'(km), 8, ef, eo, ed, ek, ec);
    @(negedge sys_clk);
    b_cmd_p = p; b_cmd_k_max = km; b_cmd_valid = 1'b1;
    @(negedge sys_clk);
    b_cmd_valid = 1'b0;
    cyc = 0;
    while (!b_result_valid && cyc < 5000) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("b_valid", 64'(b_result_valid), 64'd1);
    chk("b_found", 64'(b_result_found), 64'(ef));
    chk("b_overflow", 64'(b_result_overflow), 64'(eo));
    chk("b_res_d", 64'(b_result_d), ed);
    chk("b_res_k", 64'(b_result_k), ek);
    chk("b_tested", 64'(b_tested_count), ec);
    b_result_ready = 1'b1;
    @(negedge sys_clk);
    b_result_ready = 1'b0;
    chk("b_back_idle", 64'(b_cmd_ready), 64'd1);
  endtask

  initial begin
    logic [BW-1:0] rp;
    logic [KW-1:0] rk;
    int cyc;
    cmd_valid = 0; cmd_p = '0; cmd_k_max = '0; result_ready = 0;
    b_cmd_valid = 0; b_cmd_p = '0; b_cmd_k_max = '0; b_result_ready = 0;
    sys_rst = 1'b0;
    #1 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_start", 64'(tif.test_start), 64'd0);
    chk("rst_tested", 64'(tested_count), 64'd0);
    sys_rst = 1'b0;

    run_cmd(32'd11, 16'd100, 0);
    run_cmd(32'd13, 16'd4, 0);
    run_cmd(32'd29, 16'd10, 0);
    run_cmd(32'd11, 16'd100, 20);
    run_cmd(32'd1, 16'd5, 0);
    run_cmd(32'd7, 16'd0, 0);
    run_cmd(32'h8000_0001, 16'd3, 0);
    run_cmd(32'h7fff_fff0, 16'd10, 0);

    run8(8'd127, 16'd5);
    run8(8'd3, 16'd40);
    run8(8'd5, 16'd30);
    run8(8'd200, 16'd3);
    run8(8'd11, 16'd20);

    t_ignore_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: rp = BW'($urandom_range(2, 200));
        1: rp = BW'($urandom_range(2, 5000));
        2: rp = 32'h7fff_0000 | BW'($urandom_range(0, 16'hffff));
        default: rp = BW'($urandom);
      endcase
      rk = KW'($urandom_range(0, 120));
      run_cmd(rp, rk, 0);
    end
    t_ignore_en = 1'b0;

    // Reset while the tester is mid-test on p=13.
    t_lat_min = 8; t_lat_max = 8;
    @(negedge sys_clk);
    cmd_p = 32'd13; cmd_k_max = 16'd4; cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!tif.test_start && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("saw_issue", 64'(tif.test_start), 64'd1);
    repeat (3) @(negedge sys_clk);
    chk("in_wait_done", 64'(tif.test_finished), 64'd0);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_outputs", {busy, result_valid, result_found,
        result_overflow, tif.test_start, result_d, result_k,
        tested_count, tif.test_p, tif.test_d}, '0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    t_lat_min = 1; t_lat_max = 4;
    run_cmd(32'd11, 16'd100, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
